// File: rtl/aisys_pkg.sv
// Shared definitions for the matrix-multiplier datapath blocks.
//   stream_state_e : state encoding of the result streamer FSM.
//   idx_w(n)       : width of an index counting 0..n-1, never less than 1 bit.
//   flat_idx(r,c,n): row-major element number of (r,c) in a matrix with n
//                    columns; the operand loader uses the same mapping.
package aisys_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_e;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int flat_idx(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/matmul_result_streamer.sv
// Drain-side companion of the matrix multiplier. On a rising edge of
// res_done the whole LEFT_SIZE x RIGHT_SIZE result is snapshotted into a
// local buffer, then streamed out row-major, one element per valid/ready
// handshake. The snapshot lets the multiplier start its next job while the
// previous result drains.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   res_flat    result matrix, element (i,j) at [(i*RIGHT_SIZE+j)*DATA_W +: DATA_W]
//   res_done    multiplier done level; each rising edge marks a new result
//   m_valid     stream element valid
//   m_ready     downstream ready
//   m_data      current element
//   m_row/m_col row/column index of m_data
//   m_last      high with the final element
//   busy        high from capture until the last handshake completes
//   overrun     sticky: a result arrived mid-stream and was dropped
//   ovr_clr     synchronous clear of overrun (a simultaneous set wins)
module matmul_result_streamer
  import aisys_pkg::*;
#(
  parameter int LEFT_SIZE  = 2,
  parameter int RIGHT_SIZE = 4,
  parameter int DATA_W     = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [LEFT_SIZE*RIGHT_SIZE*DATA_W-1:0] res_flat,
  input  logic                                   res_done,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [DATA_W-1:0]                      m_data,
  output logic [idx_w(LEFT_SIZE)-1:0]            m_row,
  output logic [idx_w(RIGHT_SIZE)-1:0]           m_col,
  output logic                                   m_last,
  output logic                                   busy,
  output logic                                   overrun,
  input  logic                                   ovr_clr
);

  localparam int N_ELEM = LEFT_SIZE * RIGHT_SIZE;
  localparam int ROW_W  = idx_w(LEFT_SIZE);
  localparam int COL_W  = idx_w(RIGHT_SIZE);
  localparam int ELEM_W = idx_w(N_ELEM);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(LEFT_SIZE - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(RIGHT_SIZE - 1);

  // Packed so a whole res_flat copies in directly; element k lands in buf[k].
  typedef logic [N_ELEM-1:0][DATA_W-1:0] buf_t;

  stream_state_e    state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  buf_t             buf_q, buf_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;

  logic              done_rise;
  logic              handshake;
  logic              at_last;
  logic [ELEM_W-1:0] elem_idx;

  assign done_rise = res_done & ~done_q;
  assign handshake = m_valid & m_ready;
  assign at_last   = (row_q == LAST_ROW) && (col_q == LAST_COL);

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    buf_d     = buf_q;
    done_d    = res_done;
    overrun_d = overrun_q;

    if (ovr_clr) overrun_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (done_rise) begin
          buf_d   = res_flat;
          row_d   = '0;
          col_d   = '0;
          state_d = STREAM;
        end
      end

      STREAM: begin
        if (handshake && at_last) begin
          if (done_rise) begin
            // Back-to-back: the new result takes over with no bubble.
            buf_d = res_flat;
            row_d = '0;
            col_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (handshake) begin
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
          // Set is evaluated after the clear so it wins a tie.
          if (done_rise) overrun_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  // NOTE: the buffer is reset as well, so m_data reads 0 out of reset rather
  // than whatever the storage powered up with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      buf_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      buf_q     <= buf_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign elem_idx = ELEM_W'(flat_idx(int'(row_q), int'(col_q), RIGHT_SIZE));

  assign m_valid = (state_q == STREAM);
  assign busy    = m_valid;
  assign m_data  = buf_q[elem_idx];
  assign m_row   = row_q;
  assign m_col   = col_q;
  assign m_last  = at_last & m_valid;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Scoreboard bench for matmul_result_streamer (2 x 4, 32-bit).
// The driver decides from the outstanding-element count whether a done rise
// is captured or dropped, and queues the expected row-major elements; a
// separate monitor compares every handshake and the status outputs.
module tb_matmul_result_streamer;

  localparam int L = 2;
  localparam int R = 4;
  localparam int W = 32;
  localparam int N = L * R;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N*W-1:0]   res_flat;
  logic             res_done;
  logic             m_valid;
  logic             m_ready;
  logic [W-1:0]     m_data;
  logic [0:0]       m_row;
  logic [1:0]       m_col;
  logic             m_last;
  logic             busy;
  logic             overrun;
  logic             ovr_clr;

  always #5 clk = ~clk;

  matmul_result_streamer #(.LEFT_SIZE(L), .RIGHT_SIZE(R), .DATA_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .res_flat (res_flat),
    .res_done (res_done),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_row    (m_row),
    .m_col    (m_col),
    .m_last   (m_last),
    .busy     (busy),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic [0:0]   row;
    logic [1:0]   col;
    logic         last;
  } elem_t;

  elem_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    exp_ovr   = 1'b0;
  bit    prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  bit           hold_vld = 1'b0;
  logic [W+2:0] hold_val;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld = 1'b0;
    end else begin
      check("status{valid,busy,overrun}", {61'd0, m_valid, busy, overrun},
            {61'd0, sb.size() != 0, sb.size() != 0, exp_ovr});
      if (!m_valid) check("last_when_idle", {63'd0, m_last}, 64'd0);
      if (hold_vld && m_valid) check("stable_under_stall", {29'd0, m_data, m_row, m_col}, {29'd0, hold_val});
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_element", 64'd1, 64'd0);
        end else begin
          elem_t e;
          e = sb.pop_front();
          check("element{data,row,col,last}", {28'd0, m_data, m_row, m_col, m_last}, {28'd0, e});
        end
        hold_vld = 1'b0;
      end else if (m_valid) begin
        hold_vld = 1'b1;
        hold_val = {m_data, m_row, m_col};
      end else begin
        hold_vld = 1'b0;
      end
    end
  end

  // ---------------- driver + reference model ----------------
  // Called just after a rising edge; returns just after the next one.
  task automatic step(input bit done, input bit ready, input bit clr);
    bit rise, cap;
    res_done = done;
    m_ready  = ready;
    ovr_clr  = clr;
    @(negedge clk);
    #1;
    // The monitor has already retired this cycle's handshake, so an empty
    // scoreboard means the block is idle or finishing its last element.
    rise = done && !prev_done;
    cap  = rise && (sb.size() == 0);
    @(posedge clk);
    prev_done = done;
    if (cap) begin
      for (int k = 0; k < N; k++) begin
        elem_t e;
        e.data = res_flat[k*W +: W];
        e.row  = 1'(k / R);
        e.col  = 2'(k % R);
        e.last = (k == N - 1);
        sb.push_back(e);
      end
    end
    if (rise && !cap) exp_ovr = 1'b1;
    else if (clr)     exp_ovr = 1'b0;
    #1;
  endtask

  task automatic load(input logic [W-1:0] base);
    for (int k = 0; k < N; k++) res_flat[k*W +: W] = base + W'(k);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {m_data, 28'd0, m_valid, busy, m_last, overrun}, 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    res_done = 1'b0;
    m_ready  = 1'b0;
    ovr_clr  = 1'b0;
    load(32'h100);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_values");
    rst_n = 1'b1;

    // Basic drain: rise at the 5th edge, continuous ready.
    repeat (4) step(0, 1, 0);
    step(1, 1, 0);
    repeat (12) step(0, 1, 0);

    // Backpressure: ready pattern 1,0,0 repeating.
    step(1, 1, 0);
    for (int i = 0; i < 30; i++) step(0, (i % 3) == 0, 0);

    // Back-to-back: new result rises on the last handshake edge.
    step(1, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0);
    load(32'h200);
    step(1, 1, 0);
    load(32'hDEAD_0000);
    repeat (12) step(1, 1, 0);
    step(0, 1, 0);

    // Overrun: rise while the 3rd element is pending, then clears.
    load(32'h100);
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    load(32'h300);
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 1);
    step(0, 0, 0);
    step(1, 0, 1);
    repeat (10) step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 0);

    // Reset mid-stream after three handshakes.
    load(32'h400);
    step(1, 1, 0);
    repeat (3) step(0, 1, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_stream");
    sb.delete();
    exp_ovr   = 1'b0;
    prev_done = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) step(0, 1, 0);
    step(1, 1, 0);
    repeat (10) step(0, 1, 0);

    // Held done: one stream only.
    load(32'h500);
    repeat (20) step(1, 1, 0);
    step(0, 1, 0);
    repeat (3) step(0, 1, 0);

    // Randomized traffic, res_flat scrambled every cycle.
    for (int i = 0; i < 800; i++) begin
      bit d;
      for (int k = 0; k < N; k++) res_flat[k*W +: W] = $urandom;
      d = ($urandom_range(0, 5) == 0) ? ~res_done : res_done;
      step(d, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    // Bounded drain of anything still outstanding.
    for (int i = 0; i < 40 && sb.size() != 0; i++) step(0, 1, 0);
    check("final_drain_outstanding", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_result_streamer.md
Name: matmul_result_streamer

Overview:
- Drain-side companion of the matrix multiplier; it reads the multiplier's parallel result matrix.
- On a rising edge of the multiplier's done, it snapshots the full LEFT_SIZE x RIGHT_SIZE result matrix into a local buffer.
- It then streams the buffer out one element per handshake, row-major, over a valid/ready interface.
- Because of the snapshot, the multiplier can be re-armed while the previous result is still draining.

Parameters:
- LEFT_SIZE, 2, result rows.
- RIGHT_SIZE, 4, result columns.
- DATA_W, 32, element width in bits.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset: asynchronous, active-low.
- res_flat  input  LEFT_SIZE*RIGHT_SIZE*DATA_W  result matrix; element (i,j) sits at bits [(i*RIGHT_SIZE+j)*DATA_W +: DATA_W].
- res_done  input  1  done from the multiplier; level signal, rising edge marks a new result.
- m_valid  output  1  stream element valid.
- m_ready  input  1  downstream ready.
- m_data  output  DATA_W  current element.
- m_row  output  $clog2(LEFT_SIZE) (min 1)  row index of m_data.
- m_col  output  $clog2(RIGHT_SIZE) (min 1)  column index of m_data.
- m_last  output  1  high with the final element (LEFT_SIZE-1, RIGHT_SIZE-1).
- busy  output  1  high from capture until the last handshake completes.
- overrun  output  1  sticky; a new result arrived while streaming and was dropped.
- ovr_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset values: m_valid=0, m_data=0, m_row=0, m_col=0, m_last=0, busy=0, overrun=0, buffer=0, done_q=0, state=IDLE.
- Edge detect: done_rise = res_done & ~done_q; done_q registers res_done every cycle. A res_done already high on the first clock after reset counts as a rise.
- FSM states: IDLE, STREAM.
- IDLE, on done_rise at edge N:
  - buffer <= res_flat; row/col counters <= 0; state <= STREAM.
  - m_valid=1 and busy=1 from cycle N+1, with m_data = element (0,0). Latency is 1 cycle.
- STREAM, handshake = m_valid & m_ready:
  - On handshake with a non-last element, advance col; on col wrap (RIGHT_SIZE-1 -> 0), advance row. The next element is presented in the following cycle, so the stream runs 1 element/cycle under continuous ready.
  - With no handshake, m_data, m_row, m_col and m_last hold stable. m_valid never drops before its handshake.
  - m_data, m_row, m_col and m_last are muxed combinationally from the registered buffer and counters.
  - m_last = (row==LEFT_SIZE-1)&&(col==RIGHT_SIZE-1)&&m_valid.
- Last handshake at edge K:
  - Without done_rise at K: state <= IDLE; m_valid=0 and busy=0 from cycle K+1.
  - With done_rise at K (back-to-back): capture the new result and stay in STREAM. m_valid stays 1 and element (0,0) of the new matrix appears at cycle K+1, with no bubble.
- done_rise in STREAM, not coincident with the last handshake: the new matrix is dropped and overrun <= 1. The buffer and the current stream are unaffected.
- ovr_clr: clears overrun. If ovr_clr and a set condition occur in the same cycle, the set wins.
- res_done held high: produces no further captures until it falls and rises again.
- rst_n asserted mid-stream: immediate return to all reset values. The partial stream is abandoned with no m_last.
- 1x1 configuration: a single element with m_last=1; indices are held at 0.
- res_flat is sampled only at the capture edge; changes at any other time are ignored.

Decomposition:
- Shared package aisys_pkg:
  - typedef enum {IDLE, STREAM} for the stream FSM state.
  - Function idx_w(n) = max(1,$clog2(n)).
  - Localparam-style helper for the flat-index offset, shared with the future operand loader.
- No sub-module needed. A single always_ff block holds the FSM, counters and buffer; the output mux is a combinational assign.

Test Plan (LEFT_SIZE=2, RIGHT_SIZE=4, DATA_W=32):
- Basic drain: res_flat element k = 32'h100+k; pulse res_done at edge 5; m_ready=1 -> m_valid from cycle 6, m_data 0x100..0x107 on cycles 6..13, (row,col) (0,0)..(1,3), m_last only at cycle 13, busy falls at cycle 14.
- Backpressure: same setup, m_ready toggles 1,0,0,1,... -> exactly 8 handshakes in order 0x100..0x107, m_data stable across every ready=0 cycle, no duplicates or skips.
- Back-to-back: second matrix 0x200+k with res_done rising exactly at the last handshake -> 0x200 presented on the next cycle with m_valid continuously 1; 16 total elements; overrun stays 0.
- Overrun: res_done rises while the 3rd element is pending -> overrun=1, stream continues with 0x102..0x107 unchanged; ovr_clr later -> overrun=0; ovr_clr coincident with a new overrun -> overrun stays 1.
- Reset mid-stream: rst_n low after 3 handshakes -> m_valid, busy, m_last drop immediately; after release with res_done=0 the block stays idle; a new res_done rise restarts at (0,0).
- Held done: res_done high for 20 cycles with m_ready=1 -> exactly one 8-element stream, no overrun.
